start_conditioner: RTL
======================

# start_conditioner

Upstream front end for the ones-counter datapath/controller pair. It converts the raw active-low KEY start button into a clean start level `s`, captures the switch operand at the moment of the press, and holds both stable for the whole operation. Release is honoured only after the controller reports `done`. It replaces the bare two-flop synchronizer that sits between KEY[3] and the controller's `s` input, and feeds `a_out` into the datapath's `A` port.

## Interface
- `WIDTH`, default 8: operand width. Matches the datapath `A` port.
- `DB_CYCLES`, default 16: consecutive stable cycles required before the debounced level changes. Must be ≥2. Board builds use 500000.

- `clk` in 1: system clock (CLOCK_50); all state updates on its rising edge.
- `reset` in 1: synchronous, active-high. Drives every register to its reset value on the next edge.
- `key_n` in 1: raw start button, active-low, asynchronous to `clk`, may bounce.
- `sw` in WIDTH: raw operand switches, treated as quasi-static.
- `done` in 1: controller done flag, level.
- `s` out 1: start level to the controller. Registered.
- `a_out` out WIDTH: captured operand to the datapath. Registered.
- `busy` out 1: high while in RUN or WAIT_REL. Registered.
- `op_count` out 4: number of operations started, mod 16. Registered.

## Operation
- Synchronizer: two flops sample `~key_n` to produce `key_sync`. Both flops reset to 0 (released).
- Debouncer: registers `stable` (reset 0) and `cnt` (width $clog2(DB_CYCLES), reset 0). Each edge:
  - if `key_sync==stable`, `cnt<=0`;
  - else if `cnt==DB_CYCLES-1`, `stable<=key_sync` and `cnt<=0`;
  - else `cnt<=cnt+1`.
  - Any glitch back to `stable` restarts the count.
- FSM, reset to IDLE:
  - IDLE (`s=0`, `busy=0`): if `stable==1`, capture `a_out<=sw`, increment `op_count`, and go to RUN.
  - RUN (`s=1`, `busy=1`): if `done==1`, go to WAIT_REL. Changes in `stable` are ignored while in RUN.
  - WAIT_REL (`s=1`, `busy=1`): if `stable==0`, go to IDLE. This keeps the controller parked in its done state, so the result stays displayed while the button is held.
- `a_out` changes only on the IDLE→RUN edge. Changes on `sw` at any other time have no effect.
- `op_count` wraps 15→0.
- `s`, `busy` and `op_count` are registered decodes and update on the same edge as the state change.
- Boundaries:
  - `done` and a release in the same RUN cycle: go to WAIT_REL; IDLE follows one edge later.
  - `done` asserted while in IDLE: ignored.
  - Button held through reset: after reset deasserts, the press is re-debounced from `cnt=0` and starts a new operation.
  - `reset` mid-operation: state IDLE, `s=0`, `busy=0`, `a_out=0`, `op_count=0`, `stable=0`, `cnt=0`. The controller then sees `s=0`.

## Timing
- The raw press is first sampled at edge k. `key_sync` is high after edge k+1.
- With debounce: `stable` rises after edge k+1+DB_CYCLES, and `s`/`busy`/`a_out` update after edge k+2+DB_CYCLES.
- Release follows the same path. `s` falls DB_CYCLES+2 edges after the release is sampled, provided `done` was already seen.
- `done` is acted on at the next edge, with one cycle of latency from RUN to WAIT_REL.
- Minimum press-to-press period: one IDLE cycle between operations.

## Configuration
- `START_DEBOUNCE_EN`
  - Defined: the debouncer above is compiled in.
  - Undefined: the `cnt` logic is removed and `stable` is `key_sync` directly. `s` rises after edge k+2, `DB_CYCLES` is unused, and all FSM behaviour is unchanged.

## Test plan
- Reset: `key_n=0`, `reset=1` for 3 cycles → `s=0`, `busy=0`, `a_out=0`, `op_count=0`. Then release reset with the key still held → `s` rises DB_CYCLES+2 edges later.
- Clean press (DB_CYCLES=4, macro on): `sw=8'hA5`, `key_n` falls before edge k → `s=1` and `a_out=8'hA5` after edge k+6, `op_count=1`. Set `sw=8'hFF` → `a_out` stays `8'hA5`.
- Bounce: toggle `key_n` every 2 cycles for 12 cycles, then hold low → `s` stays 0 until 4 consecutive stable cycles have passed, then rises exactly once. `op_count` increments by exactly 1.
- Hold and done: keep the key pressed, pulse `done` for 1 cycle → `s` stays 1 (WAIT_REL). Release → `s=0` and `busy=0` 6 edges after the release is sampled. A second press → `op_count=2`.
- Release before done: release in RUN → `s` stays 1. `done=1` → WAIT_REL at the next edge, IDLE the edge after.
- Wrap and mid-op reset: 16 full operations → `op_count=0`. Assert `reset` during RUN → all outputs 0 on the next edge. Macro off: press → `s` high after edge k+2.

Source files
------------

// File: rtl/start_conditioner.sv
// start_conditioner: cleans the active-low KEY start button into a start level
// `s` for the ones-counter controller and latches the switch operand at press.
// Optional feature macro: START_DEBOUNCE_EN. When defined, a DB_CYCLES
// debouncer sits between the synchroniser and the FSM. When undefined, the
// synchronised key drives the FSM directly and DB_CYCLES is unused.
module start_conditioner #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             done,
  output logic             s,
  output logic [WIDTH-1:0] a_out,
  output logic             busy,
  output logic [3:0]       op_count
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_REL} state_t;

  state_t           state_q;
  state_t           state_d;
  logic             key_meta;
  logic             key_sync;
  logic             stable;
  logic [WIDTH-1:0] a_d;
  logic [3:0]       op_d;

  // A debounce window shorter than two cycles cannot be represented.
  if (DB_CYCLES < 2) begin : g_db_cycles_check
    $error("start_conditioner: DB_CYCLES must be at least 2");
  end

  // Two-flop synchroniser on the inverted key, so 1 means pressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= ~key_n;
      key_sync <= key_meta;
    end
  end

`ifdef START_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Accept a new level only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (key_sync == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= key_sync;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign stable = key_sync;
`endif

  // Next-state logic; operand capture and count happen only on IDLE->RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_out;
    op_d    = op_count;
    case (state_q)
      IDLE: begin
        if (stable) begin
          state_d = RUN;
          a_d     = sw;
          op_d    = op_count + 4'd1;
        end
      end
      RUN: begin
        if (done) state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (!stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered output decodes, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      s        <= 1'b0;
      busy     <= 1'b0;
      a_out    <= '0;
      op_count <= 4'd0;
    end else begin
      state_q  <= state_d;
      s        <= (state_d != IDLE);
      busy     <= (state_d != IDLE);
      a_out    <= a_d;
      op_count <= op_d;
    end
  end

endmodule
